// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the read side of a byte FIFO and shifts each out
// as a start/8-data/stop serial frame, holding every bit for CLKS_PER_BIT clocks.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
  localparam logic [7:0] TC = 8'(CLKS_PER_BIT - 1);
  state_t state, state_n;
  logic [7:0] div, shift;
  logic [2:0] bit_cnt;
  logic tc;
  assign tc = div == TC;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fifo_empty ? IDLE : FETCH;
      FETCH:   state_n = LOAD;
      LOAD:    state_n = START;
      START:   state_n = tc ? DATA : START;
      DATA:    state_n = (tc && bit_cnt == 3'd7) ? STOP : DATA;
      STOP:    state_n = tc ? (fifo_empty ? IDLE : FETCH) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // Outputs decode from state and the shift register only, never from inputs.
  assign fifo_rd = state == FETCH;
  assign busy    = state != IDLE;
  assign tx      = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div         <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      div         <= (state_n != state || tc || state == IDLE) ? '0 : div + 8'd1;
      shift       <= state == LOAD ? fifo_data : (state == DATA && tc) ? shift >> 1 : shift;
      bit_cnt     <= state == START ? '0 : (state == DATA && tc) ? bit_cnt + 3'd1 : bit_cnt;
      frame_count <= (state == STOP && tc) ? frame_count + 8'd1 : frame_count;
    end
  end
endmodule
